// File: rtl/wb_user_fabric.sv
// Wishbone fabric: decodes the Caravel user port onto NUM_SLAVES peripherals,
// with a status register, decode-error responses and a per-access timeout watchdog.
module wb_user_fabric #(
    parameter int unsigned NUM_SLAVES = 4,
    parameter int unsigned SLAVE_AW   = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int unsigned TIMEOUT    = 255,
    parameter logic [31:0] ERR_DATA   = 32'hDEAD_BEEF
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic                     wbs_cyc_i,
    input  logic                     wbs_stb_i,
    input  logic                     wbs_we_i,
    input  logic [3:0]               wbs_sel_i,
    input  logic [31:0]              wbs_adr_i,
    input  logic [31:0]              wbs_dat_i,
    output logic [31:0]              wbs_dat_o,
    output logic                     wbs_ack_o,
    output logic [NUM_SLAVES-1:0]    s_cyc_o,
    output logic [NUM_SLAVES-1:0]    s_stb_o,
    output logic                     s_we_o,
    output logic [3:0]               s_sel_o,
    output logic [31:0]              s_adr_o,
    output logic [31:0]              s_dat_o,
    input  logic [32*NUM_SLAVES-1:0] s_dat_i,
    input  logic [NUM_SLAVES-1:0]    s_ack_i
);

    localparam int unsigned IDX_W = 4;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned DW    = 32;
    localparam logic [IDX_W-1:0] STATUS_IDX = 4'hF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NUM_SLAVES-1:0]   stb_q, stb_d;
    logic                    we_q, we_d;
    logic [3:0]              sel_q, sel_d;
    logic [DW-1:0]           adr_q, adr_d;
    logic [DW-1:0]           wdat_q, wdat_d;
    logic                    ack_q, ack_d;
    logic [DW-1:0]           rdat_q, rdat_d;
    logic [DW-1:0]           status_q, status_d;

    logic [IDX_W-1:0]        req_idx_c;
    logic                    region_hit_c;
    logic                    slave_hit_c;
    logic                    status_hit_c;
    logic                    sel_ack_c;
    logic [DW-1:0]           sel_dat_c;
    logic                    timeout_hit_c;

    // Address decode of the incoming request and mux of the selected slave's response
    always_comb begin
        req_idx_c     = wbs_adr_i[SLAVE_AW +: IDX_W];
        region_hit_c  = (wbs_adr_i[31:24] == BASE_ADDR[31:24]);
        slave_hit_c   = region_hit_c && (req_idx_c < IDX_W'(NUM_SLAVES));
        status_hit_c  = region_hit_c && (req_idx_c == STATUS_IDX);
        timeout_hit_c = (cnt_q == CNT_W'(TIMEOUT - 1));
        sel_ack_c     = 1'b0;
        sel_dat_c     = '0;
        for (int k = 0; k < int'(NUM_SLAVES); k++) begin
            if (idx_q == IDX_W'(k)) begin
                sel_ack_c = s_ack_i[k];
                sel_dat_c = s_dat_i[DW*k +: DW];
            end
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        stb_d    = stb_q;
        we_d     = we_q;
        sel_d    = sel_q;
        adr_d    = adr_q;
        wdat_d   = wdat_q;
        ack_d    = 1'b0;
        rdat_d   = rdat_q;
        status_d = status_q;

        unique case (state_q)
            IDLE: begin
                if (wbs_cyc_i && wbs_stb_i) begin
                    if (slave_hit_c) begin
                        idx_d  = req_idx_c;
                        we_d   = wbs_we_i;
                        sel_d  = wbs_sel_i;
                        adr_d  = wbs_adr_i;
                        wdat_d = wbs_dat_i;
                        cnt_d  = '0;
                        for (int k = 0; k < int'(NUM_SLAVES); k++) begin
                            stb_d[k] = (req_idx_c == IDX_W'(k));
                        end
                        state_d = ACTIVE;
                    end else if (status_hit_c) begin
                        if (wbs_we_i) begin
                            if (wbs_sel_i[0]) begin
                                status_d[1:0] = status_q[1:0] & ~wbs_dat_i[1:0];
                            end
                            if ((wbs_sel_i[3:2] == 2'b11) && wbs_dat_i[31]) begin
                                status_d[31:16] = '0;
                            end
                        end else begin
                            rdat_d = status_q;
                        end
                        ack_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        status_d[1] = 1'b1;
                        if (!wbs_we_i) begin
                            rdat_d = ERR_DATA;
                        end
                        ack_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end

            ACTIVE: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Ack has priority over a coincident timeout
                if (sel_ack_c) begin
                    rdat_d  = sel_dat_c;
                    stb_d   = '0;
                    ack_d   = 1'b1;
                    state_d = RESP;
                end else if (timeout_hit_c) begin
                    stb_d         = '0;
                    status_d[0]   = 1'b1;
                    status_d[7:4] = idx_q;
                    if (status_q[31:16] != 16'hFFFF) begin
                        status_d[31:16] = status_q[31:16] + 16'd1;
                    end
                    rdat_d  = ERR_DATA;
                    ack_d   = 1'b1;
                    state_d = RESP;
                end else if (!wbs_cyc_i) begin
                    stb_d   = '0;
                    state_d = IDLE;
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                stb_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            stb_q    <= '0;
            we_q     <= 1'b0;
            sel_q    <= '0;
            adr_q    <= '0;
            wdat_q   <= '0;
            ack_q    <= 1'b0;
            rdat_q   <= '0;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            stb_q    <= stb_d;
            we_q     <= we_d;
            sel_q    <= sel_d;
            adr_q    <= adr_d;
            wdat_q   <= wdat_d;
            ack_q    <= ack_d;
            rdat_q   <= rdat_d;
            status_q <= status_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = rdat_q;
    assign s_cyc_o   = stb_q;
    assign s_stb_o   = stb_q;
    assign s_we_o    = we_q;
    assign s_sel_o   = sel_q;
    assign s_adr_o   = adr_q;
    assign s_dat_o   = wdat_q;

endmodule

// File: tb/tb_wb_user_fabric.sv
// Bench for wb_user_fabric: directed vector table, hand sequences for abort/reset/
// coincident ack, then random transactions against a transaction-level model.
module tb_wb_user_fabric;

    localparam int NS = 4;
    localparam int TO = 255;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic            clk = 1'b0;
    logic            rst;
    logic            cyc, stb, we;
    logic [3:0]      sel;
    logic [31:0]     adr, wdat;
    logic [31:0]     wbs_dat_o;
    logic            wbs_ack_o;
    logic [NS-1:0]   s_cyc_o, s_stb_o;
    logic            s_we_o;
    logic [3:0]      s_sel_o;
    logic [31:0]     s_adr_o, s_dat_o;
    logic [32*NS-1:0] s_dat_i;
    logic [NS-1:0]   s_ack_i;

    always #5 clk = ~clk;

    wb_user_fabric dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wbs_cyc_i(cyc),
        .wbs_stb_i(stb),
        .wbs_we_i (we),
        .wbs_sel_i(sel),
        .wbs_adr_i(adr),
        .wbs_dat_i(wdat),
        .wbs_dat_o(wbs_dat_o),
        .wbs_ack_o(wbs_ack_o),
        .s_cyc_o  (s_cyc_o),
        .s_stb_o  (s_stb_o),
        .s_we_o   (s_we_o),
        .s_sel_o  (s_sel_o),
        .s_adr_o  (s_adr_o),
        .s_dat_o  (s_dat_o),
        .s_dat_i  (s_dat_i),
        .s_ack_i  (s_ack_i)
    );

    // Behavioural slaves: ack after wait_cfg[k] strobed cycles (-1 = never)
    int           wait_cfg [NS];
    logic [31:0]  rdata_cfg[NS];
    int           wcnt     [NS];
    logic [NS-1:0] noise;

    always_ff @(posedge clk) begin
        for (int k = 0; k < NS; k++) begin
            if (s_stb_o[k] && !s_ack_i[k]) wcnt[k] <= wcnt[k] + 1;
            else                           wcnt[k] <= 0;
        end
    end

    always_comb begin
        s_ack_i = '0;
        s_dat_i = '0;
        for (int k = 0; k < NS; k++) begin
            s_dat_i[32*k +: 32] = rdata_cfg[k];
            if (s_stb_o[k]) s_ack_i[k] = (wait_cfg[k] >= 0) && (wcnt[k] == wait_cfg[k]);
            else            s_ack_i[k] = noise[k];
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Transaction-level model of the status register state
    bit   m_to, m_de;
    logic [3:0] m_last;
    int   m_cnt;

    function automatic logic [31:0] m_status();
        return {16'(m_cnt), 8'h00, m_last, 2'b00, m_de, m_to};
    endfunction

    task automatic model_reset();
        m_to = 0; m_de = 0; m_last = '0; m_cnt = 0;
    endtask

    task automatic model_txn(input logic [31:0] a, input logic w, input logic [3:0] s,
                             input logic [31:0] d, output int lat, output logic [31:0] rd,
                             output bit chk, output int stbc);
        int idx;
        bit hit;
        idx = int'(a[19:16]);
        hit = (a[31:24] == 8'h30);
        rd  = '0;
        if (hit && idx < NS) begin
            if (wait_cfg[idx] >= 0 && wait_cfg[idx] <= TO - 1) begin
                lat = 2 + wait_cfg[idx];
                rd  = rdata_cfg[idx];
            end else begin
                lat = TO + 1;
                rd  = ERR;
                m_to = 1;
                m_last = a[19:16];
                if (m_cnt < 65535) m_cnt++;
            end
            chk  = !w;
            stbc = lat - 1;
        end else if (hit && idx == 15) begin
            lat = 1; stbc = 0;
            if (w) begin
                chk = 0;
                if (s[0]) begin
                    if (d[0]) m_to = 0;
                    if (d[1]) m_de = 0;
                end
                if (s[3:2] == 2'b11 && d[31]) m_cnt = 0;
            end else begin
                chk = 1;
                rd  = m_status();
            end
        end else begin
            m_de = 1;
            lat = 1; stbc = 0;
            rd  = ERR;
            chk = !w;
        end
    endtask

    // Drive one master access and measure latency, data and slave-side behaviour
    task automatic run_txn(input logic [31:0] a, input logic w, input logic [3:0] s,
                           input logic [31:0] d, input bit noisy,
                           output int lat, output logic [31:0] rd, output int stbc, output int bad);
        logic [NS-1:0] exp_oh;
        exp_oh = '0;
        if (int'(a[19:16]) < NS) exp_oh[a[19:16]] = 1'b1;
        @(posedge clk); #1;
        cyc = 1; stb = 1; we = w; sel = s; adr = a; wdat = d;
        lat = -1; rd = '0; stbc = 0; bad = 0;
        for (int c = 1; c <= 400; c++) begin
            @(posedge clk); #1;
            noise = noisy ? NS'($urandom) : '0;
            if (s_stb_o != '0) begin
                stbc++;
                if (s_stb_o !== exp_oh || s_cyc_o !== s_stb_o) bad++;
                if (s_adr_o !== a || s_we_o !== w || s_sel_o !== s || (w && s_dat_o !== d)) bad++;
            end
            if (wbs_ack_o === 1'b1) begin
                lat = c;
                rd  = wbs_dat_o;
                break;
            end
        end
        cyc = 0; stb = 0; we = 0;
        noise = '0;
    endtask

    task automatic do_txn(input string nm, input logic [31:0] a, input logic w, input logic [3:0] s,
                          input logic [31:0] d, input bit noisy, input bit use_vec,
                          input int v_lat, input logic [31:0] v_dat, input bit v_chk);
        int m_lat, m_stbc, lat, stbc, bad;
        logic [31:0] m_d, rd;
        bit m_chk;
        model_txn(a, w, s, d, m_lat, m_d, m_chk, m_stbc);
        if (use_vec) begin
            m_lat = v_lat; m_d = v_dat; m_chk = v_chk;
        end
        run_txn(a, w, s, d, noisy, lat, rd, stbc, bad);
        check($sformatf("%s.latency", nm), 32'(lat), 32'(m_lat));
        if (m_chk) check($sformatf("%s.rdata", nm), rd, m_d);
        check($sformatf("%s.stb_cycles", nm), 32'(stbc), 32'(m_stbc));
        check($sformatf("%s.slave_bus", nm), 32'(bad), 32'd0);
        @(posedge clk); #1;
        check($sformatf("%s.ack_pulse", nm), 32'(wbs_ack_o), 32'd0);
    endtask

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] dat;
        int          wt;
        logic [31:0] rdat;
        int          lat;
        logic [31:0] exp;
        bit          chk;
    } vec_t;

    vec_t vecs[15];

    initial begin
        int n_ack;
        logic [31:0] a;
        int r, ix;

        vecs[0]  = '{32'h3000_0000, 1'b0, 4'hF, 32'h0,         0,  32'h1234_5678, 2,   32'h1234_5678, 1'b1};
        vecs[1]  = '{32'h3002_0010, 1'b1, 4'hF, 32'hA5A5_0000, 3,  32'h0BAD_0BAD, 5,   32'h0,         1'b0};
        vecs[2]  = '{32'h300F_0000, 1'b0, 4'hF, 32'h0,         0,  32'h0,         1,   32'h0000_0000, 1'b1};
        vecs[3]  = '{32'h3001_0000, 1'b0, 4'hF, 32'h0,         -1, 32'h1111_1111, 256, 32'hDEAD_BEEF, 1'b1};
        vecs[4]  = '{32'h300F_0000, 1'b0, 4'hF, 32'h0,         0,  32'h0,         1,   32'h0001_0011, 1'b1};
        vecs[5]  = '{32'h4000_0000, 1'b0, 4'hF, 32'h0,         0,  32'h0,         1,   32'hDEAD_BEEF, 1'b1};
        vecs[6]  = '{32'h3005_0000, 1'b0, 4'hF, 32'h0,         0,  32'h0,         1,   32'hDEAD_BEEF, 1'b1};
        vecs[7]  = '{32'h300F_0000, 1'b0, 4'hF, 32'h0,         0,  32'h0,         1,   32'h0001_0013, 1'b1};
        vecs[8]  = '{32'h300F_0000, 1'b1, 4'h1, 32'h0000_0003, 0,  32'h0,         1,   32'h0,         1'b0};
        vecs[9]  = '{32'h300F_0000, 1'b0, 4'hF, 32'h0,         0,  32'h0,         1,   32'h0001_0010, 1'b1};
        vecs[10] = '{32'h300F_0000, 1'b1, 4'hC, 32'h8000_0000, 0,  32'h0,         1,   32'h0,         1'b0};
        vecs[11] = '{32'h300F_0000, 1'b0, 4'hF, 32'h0,         0,  32'h0,         1,   32'h0000_0010, 1'b1};
        vecs[12] = '{32'h3003_0004, 1'b1, 4'h3, 32'h0000_BEEF, 1,  32'h0,         3,   32'h0,         1'b0};
        vecs[13] = '{32'h300E_0000, 1'b1, 4'hF, 32'h1234_0000, 0,  32'h0,         1,   32'h0,         1'b0};
        vecs[14] = '{32'h300F_0000, 1'b0, 4'hF, 32'h0,         0,  32'h0,         1,   32'h0000_0012, 1'b1};

        cyc = 0; stb = 0; we = 0; sel = '0; adr = '0; wdat = '0; noise = '0;
        for (int k = 0; k < NS; k++) begin
            wait_cfg[k] = 0; rdata_cfg[k] = '0;
        end
        model_reset();

        rst = 1;
        repeat (3) @(posedge clk);
        #1;
        check("reset.ack", 32'(wbs_ack_o), 32'd0);
        check("reset.cyc_stb", {24'd0, s_cyc_o, s_stb_o}, 32'd0);
        check("reset.dat_o", wbs_dat_o, 32'd0);
        check("reset.s_bus", s_adr_o | s_dat_o | 32'(s_sel_o) | 32'(s_we_o), 32'd0);
        rst = 0;

        for (int i = 0; i < 15; i++) begin
            ix = int'(vecs[i].adr[19:16]);
            if (vecs[i].adr[31:24] == 8'h30 && ix < NS) begin
                wait_cfg[ix]  = vecs[i].wt;
                rdata_cfg[ix] = vecs[i].rdat;
            end
            do_txn($sformatf("vec%0d", i), vecs[i].adr, vecs[i].we, vecs[i].sel, vecs[i].dat,
                   1'b0, 1'b1, vecs[i].lat, vecs[i].exp, vecs[i].chk);
        end

        // Master abort two cycles into a slave3 access
        wait_cfg[3] = -1;
        @(posedge clk); #1;
        cyc = 1; stb = 1; we = 0; sel = 4'hF; adr = 32'h3003_0000;
        @(posedge clk); #1;
        check("abort.cyc_up", 32'(s_cyc_o), 32'h8);
        @(posedge clk); #1;
        cyc = 0; stb = 0;
        @(posedge clk); #1;
        check("abort.cyc_down", {24'd0, s_cyc_o, s_stb_o}, 32'd0);
        n_ack = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (wbs_ack_o) n_ack++;
        end
        check("abort.no_ack", 32'(n_ack), 32'd0);
        wait_cfg[3] = 0; rdata_cfg[3] = 32'hCAFE_0003;
        do_txn("after_abort", 32'h3003_0008, 1'b0, 4'hF, 32'h0, 1'b0, 1'b1, 2, 32'hCAFE_0003, 1'b1);

        // Reset in the middle of a slave1 access
        wait_cfg[1] = -1;
        @(posedge clk); #1;
        cyc = 1; stb = 1; we = 1; sel = 4'hF; adr = 32'h3001_0020; wdat = 32'h5555_AAAA;
        repeat (3) @(posedge clk);
        #1;
        rst = 1; cyc = 0; stb = 0; we = 0;
        @(posedge clk); #1;
        check("midrst.ack", 32'(wbs_ack_o), 32'd0);
        check("midrst.cyc_stb", {24'd0, s_cyc_o, s_stb_o}, 32'd0);
        check("midrst.dat_o", wbs_dat_o, 32'd0);
        check("midrst.s_bus", s_adr_o | s_dat_o | 32'(s_sel_o) | 32'(s_we_o), 32'd0);
        rst = 0;
        model_reset();
        n_ack = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (wbs_ack_o) n_ack++;
        end
        check("midrst.no_ack", 32'(n_ack), 32'd0);
        do_txn("midrst.status", 32'h300F_0000, 1'b0, 4'hF, 32'h0, 1'b0, 1'b1, 1, 32'h0, 1'b1);

        // Slave ack lands on the same cycle the watchdog would fire
        wait_cfg[2] = TO - 1; rdata_cfg[2] = 32'h600D_F00D;
        do_txn("coincide", 32'h3002_0000, 1'b0, 4'hF, 32'h0, 1'b0, 1'b1, TO + 1, 32'h600D_F00D, 1'b1);
        do_txn("coincide.status", 32'h300F_0000, 1'b0, 4'hF, 32'h0, 1'b0, 1'b1, 1, 32'h0, 1'b1);

        // Random traffic checked against the model
        for (int i = 0; i < 40; i++) begin
            for (int k = 0; k < NS; k++) begin
                rdata_cfg[k] = $urandom;
                wait_cfg[k]  = ($urandom_range(0, 11) == 0) ? -1 : int'($urandom_range(0, 5));
            end
            r = int'($urandom_range(0, 9));
            a = $urandom;
            a[31:24] = 8'h30;
            if (r <= 5)      a[19:16] = 4'($urandom_range(0, NS - 1));
            else if (r == 6) a[19:16] = 4'hF;
            else if (r == 7) a[19:16] = 4'($urandom_range(NS, 14));
            else begin
                a = $urandom;
                if (a[31:24] == 8'h30) a[31:24] = 8'h31;
            end
            do_txn($sformatf("rnd%0d", i), a, 1'($urandom), 4'($urandom), $urandom,
                   1'b1, 1'b0, 0, 32'h0, 1'b0);
        end
        do_txn("final.status", 32'h300F_0000, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0, 0, 32'h0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
